// File: rtl/rv32i_if_stage.sv
// RV32IM fetch stage: owns fetch PC, issues imem valid/ready requests, buffers responses in order; response->if_valid 1 cycle.
// Stalls requests once outstanding+buffered reaches BUF_DEPTH; redirects flush and drop stale responses. Trap: RV32_IF_MISALIGN_TRAP_EN.
module rv32i_if_stage #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned      BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_instr,
  output logic [WIDTH-1:0] if_pc,
  input  logic             id_ready,
  output logic             misalign_fault,
  output logic [WIDTH-1:0] fault_pc
);
  localparam int unsigned      AW      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned      CW      = $clog2(2 * BUF_DEPTH + 1);
  localparam logic [AW-1:0]    LAST    = AW'(BUF_DEPTH - 1);
  localparam logic [CW-1:0]    DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [WIDTH-1:0] NOP     = WIDTH'(32'h0000_0013);

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             run_q;
  logic [CW-1:0]    out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [AW-1:0]    pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
  logic [AW-1:0]    buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
  logic [WIDTH-1:0] pend_pc_q [BUF_DEPTH];
  logic [WIDTH-1:0] buf_pc_q  [BUF_DEPTH];
  logic [WIDTH-1:0] buf_ins_q [BUF_DEPTH];

  logic             pop, req_fire, rsp_acc, buf_push, buf_pop, halted;
  logic [CW-1:0]    occ;
  logic [WIDTH-1:0] target;

`ifdef RV32_IF_MISALIGN_TRAP_EN
  logic             halt_q, halt_d, fault_q, fault_d, misaligned;
  logic [WIDTH-1:0] fault_pc_q, fault_pc_d;

  assign misaligned     = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign target         = redirect_pc;
  assign halted         = halt_q;
  assign misalign_fault = fault_q;
  assign fault_pc       = fault_pc_q;

  // Any redirect re-decides the halt: aligned resumes, misaligned (re)traps.
  always_comb begin
    halt_d     = halt_q;
    fault_d    = misaligned;
    fault_pc_d = fault_pc_q;
    if (redirect_valid) halt_d = misaligned;
    if (misaligned) fault_pc_d = redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      halt_q     <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      halt_q     <= halt_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb  = ^redirect_pc[1:0];
  assign target         = {redirect_pc[WIDTH-1:2], 2'b00};
  assign halted         = 1'b0;
  assign misalign_fault = 1'b0;
  assign fault_pc       = '0;
`endif

  assign pop            = if_valid & id_ready;
  assign occ            = out_q + cnt_q - CW'(pop);
  // run_q keeps requests off until the first clock edge out of reset.
  assign imem_req_valid = run_q & ~redirect_valid & ~halted & (occ < DEPTH_C);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign rsp_acc        = imem_rsp_valid & (out_q != '0);
  assign buf_push       = rsp_acc & (drop_q == '0) & ~redirect_valid;
  assign buf_pop        = pop & ~redirect_valid;

  assign if_valid = (cnt_q != '0);
  assign if_instr = if_valid ? buf_ins_q[buf_rd_q] : NOP;
  assign if_pc    = if_valid ? buf_pc_q[buf_rd_q] : '0;

  always_comb begin
    pc_d      = pc_q;
    out_d     = out_q + CW'(req_fire) - CW'(rsp_acc);
    drop_d    = drop_q;
    cnt_d     = cnt_q + CW'(buf_push) - CW'(buf_pop);
    pend_wr_d = pend_wr_q;
    pend_rd_d = pend_rd_q;
    buf_wr_d  = buf_wr_q;
    buf_rd_d  = buf_rd_q;
    if (req_fire) begin
      pc_d      = pc_q + WIDTH'(4);
      pend_wr_d = ptr_inc(pend_wr_q);
    end
    if (rsp_acc) begin
      pend_rd_d = ptr_inc(pend_rd_q);
      if (drop_q != '0) drop_d = drop_q - CW'(1);
    end
    if (buf_push) buf_wr_d = ptr_inc(buf_wr_q);
    if (buf_pop)  buf_rd_d = ptr_inc(buf_rd_q);
    // Pending FIFO is not flushed: stale responses still retire their entries.
    if (redirect_valid) begin
      pc_d     = target;
      drop_d   = out_q - CW'(rsp_acc);
      cnt_d    = '0;
      buf_wr_d = '0;
      buf_rd_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      run_q     <= 1'b0;
      out_q     <= '0;
      drop_q    <= '0;
      cnt_q     <= '0;
      pend_wr_q <= '0;
      pend_rd_q <= '0;
      buf_wr_q  <= '0;
      buf_rd_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      run_q     <= 1'b1;
      out_q     <= out_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
      pend_wr_q <= pend_wr_d;
      pend_rd_q <= pend_rd_d;
      buf_wr_q  <= buf_wr_d;
      buf_rd_q  <= buf_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pend_pc_q[pend_wr_q] <= pc_q;
    if (buf_push) begin
      buf_pc_q[buf_wr_q]  <= pend_pc_q[pend_rd_q];
      buf_ins_q[buf_wr_q] <= imem_rsp_data;
    end
  end

endmodule

// File: doc/rv32i_if_stage.md
# rv32i_if_stage

Instruction-fetch stage of the RV32IM pipelined core. It sits directly upstream of the IF/ID register and decode. It owns the fetch PC, issues requests to instruction memory over a valid/ready handshake, and buffers returned instructions in a small in-order FIFO. It accepts branch/jump redirects from EX and discards any in-flight responses made stale by a redirect.

## Interface
- `WIDTH`, 32: address/data width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `BUF_DEPTH`, 2: fetch-buffer entries; also the maximum of outstanding requests plus buffered entries.

- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset).
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  WIDTH  fetch address (= fetch PC).
- `imem_rsp_valid`  in  1  response valid; responses are in order and always accepted.
- `imem_rsp_data`  in  WIDTH  instruction word.
- `redirect_valid`  in  1  EX redirect (taken branch/jump).
- `redirect_pc`  in  WIDTH  redirect target.
- `if_valid`  out  1  instruction available to decode.
- `if_instr`  out  WIDTH  instruction; 32'h0000_0013 (NOP) whenever `if_valid`=0.
- `if_pc`  out  WIDTH  PC of `if_instr`; 0 whenever `if_valid`=0.
- `id_ready`  in  1  decode consumes the head entry.
- `misalign_fault`  out  1  one-cycle pulse on a misaligned redirect (see Configuration).
- `fault_pc`  out  WIDTH  offending target; 0 at reset.

## Operation
- State:
  - fetch PC;
  - pending-PC FIFO, which records the PC of each accepted request;
  - fetch buffer of {pc, instr}, `BUF_DEPTH` entries;
  - outstanding counter;
  - drop counter.
- Pop: `pop` = `if_valid` & `id_ready`.
- Issue condition: `imem_req_valid` = !`redirect_valid` & !halted & (outstanding + buf_count − pop < `BUF_DEPTH`).
  - Outstanding includes requests that will be dropped.
- Request handshake (`imem_req_valid` & `imem_req_ready`):
  - push the fetch PC onto the pending FIFO;
  - fetch PC += 4, wrapping modulo 2^32;
  - outstanding += 1.
- Response:
  - pop the pending FIFO; outstanding −= 1.
  - If drop counter > 0: discard the data and decrement the drop counter.
  - Otherwise push {pending pc, `imem_rsp_data`} into the buffer.
- A response, a buffer push and a buffer pop in the same cycle are all legal. The count changes by net effect.
- Redirect (`redirect_valid`=1):
  - fetch PC <= `redirect_pc`;
  - buffer flushed, so `if_valid`=0 the next cycle;
  - drop counter <= outstanding − (1 if a response arrives this cycle).
  - A redirect overrides a same-cycle pop or push.
  - Back-to-back redirects: the last one wins. The drop counter is recomputed each time, so it never double-counts.
- Reset (`rst`=0), including reset mid-operation:
  - fetch PC = `RESET_PC`; all counters 0; buffer empty; `imem_req_valid`=0; `misalign_fault`=0.
  - Responses arriving during reset are ignored.
  - The memory must not hold responses across a reset.

## Timing
- `imem_req_valid` and `imem_req_addr` are combinational from registered state plus `redirect_valid` and `id_ready`. No other input reaches them combinationally.
- `if_valid`, `if_instr` and `if_pc` are driven from buffer registers only.
- Latency: a response in cycle N appears on `if_valid` in cycle N+1.
- With 1-cycle memory:
  - the first request issues in the first cycle after `rst` rises (cycle 0);
  - `if_valid` first asserts in cycle 2;
  - sustained throughput is 1 instruction/cycle while `id_ready`=1 and `imem_req_ready`=1.
- While `imem_req_ready`=0 the address is held stable.
- Buffer full with `id_ready`=0: no new requests issue; no instruction is lost or duplicated.

## Configuration
- `RV32_IF_MISALIGN_TRAP_EN` defined:
  - a redirect with `redirect_pc[1:0]` != 0 is accepted as a normal redirect (flush and drop);
  - `misalign_fault` pulses for exactly 1 cycle on the next cycle, with `fault_pc` = target;
  - fetch then halts (no requests) until the next aligned redirect or reset.
  - A misaligned redirect while halted re-pulses the fault.
- Not defined:
  - `redirect_pc[1:0]` is forced to 2'b00;
  - `misalign_fault` and `fault_pc` are tied to 0;
  - there is no halt state.

## Test plan
- Reset and streaming: hold `rst`=0 for 2 cycles, then release; 1-cycle memory returning data = address.
  - Required: `imem_req_addr` 0, 4, 8, …; `if_valid` first in cycle 2; `if_pc`/`if_instr` 0, 4, 8, … on consecutive cycles.
- Backpressure: `id_ready`=0 for 5 cycles mid-stream.
  - Required: at most 2 entries buffered, requests stop, and the sequence resumes gap-free with no duplicates once `id_ready`=1.
- Stale drop: 3-cycle memory, 2 requests outstanding, redirect to 0x100.
  - Required: both old responses discarded; first delivered `if_pc`=0x100, `if_instr`=0x100.
- Double redirect: redirect to 0x200, then 0x300 on the next cycle.
  - Required: no instruction from 0x200 or earlier is delivered; first `if_pc`=0x300.
- Memory stall: `imem_req_ready`=0 for 4 cycles.
  - Required: `imem_req_addr` constant and `imem_req_valid` held high; ordering preserved after release.
- With `RV32_IF_MISALIGN_TRAP_EN` defined: redirect to 0x102.
  - Required: `misalign_fault`=1 for one cycle with `fault_pc`=0x102; no requests until a redirect to 0x104, then fetch resumes at 0x104.
